multicycle_controller: RTL and testbench

- Control FSM for the multicycle RV32I core.
- Decodes the instruction-register fields into datapath selects, write enables and the 4-bit ALU control code, and consumes the ALU Zero flag to resolve branches.
- It is the driving end of the ALU interface: it sources ALUControl and operand selects, and receives the flags.
- Handshakes with instruction/data memory via mem_ready and traps on illegal opcodes or bus timeout.

---
 rtl/multicycle_controller.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: decodes IR fields into
// datapath selects/enables/ALUControl, resolves branches, traps on faults.
// Ports: clk, rst_n; op, funct3, funct7b5, Zero, mem_ready in;
// PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
// ALUSrcB, ImmSrc, ALUControl, illegal_instr, bus_error, state_dbg out.
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_LUI,
    S_JAL,
    S_ALUWB,
    S_BRANCH,
    S_TRAP
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic       ill_set;
  logic       bus_set;
  logic       waiting;
  logic       timeout;
  logic       br_legal;
  logic       br_taken;
  logic [3:0] br_alu;

  // alt0 selects SUB for funct3 000, alt5 selects SRA for funct3 101
  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3,
    input logic       alt0,
    input logic       alt5
  );
    logic [3:0] a;
    case (f3)
      3'b000:  a = alt0 ? ALU_SUB : ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = alt5 ? ALU_SRA : ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  assign waiting = (state == S_FETCH) ||
                   (state == S_MEMREAD) ||
                   (state == S_MEMWRITE);

  // the last allowed wait cycle traps unless mem_ready arrives on it
  assign timeout = waiting && !mem_ready &&
                   (cnt == 8'(TIMEOUT_CYCLES - 1));

  assign br_legal = (funct3[2:1] != 2'b01);

  // eq/ge/geu take on Zero, ne/lt/ltu on !Zero
  assign br_taken = Zero ^ (funct3[0] ^ funct3[2]);

  always_comb begin
    case (funct3[2:1])
      2'b00:   br_alu = ALU_SUB;
      2'b10:   br_alu = ALU_SLT;
      2'b11:   br_alu = ALU_SLTU;
      default: br_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    state_n = state;
    ill_set = 1'b0;
    bus_set = 1'b0;
    case (state)
      S_FETCH:
        if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LOAD),
          (op == OP_STORE): state_n = S_MEMADR;
          (op == OP_R):     state_n = S_EXECR;
          (op == OP_I):     state_n = S_EXECI;
          (op == OP_BR):    state_n = S_BRANCH;
          (op == OP_JAL):   state_n = S_JAL;
          (op == OP_LUI):   state_n = S_LUI;
          default: begin
            state_n = S_TRAP;
            ill_set = 1'b1;
          end
        endcase
      end
      S_MEMADR:
        if (funct3 != 3'b010) begin
          state_n = S_TRAP;
          ill_set = 1'b1;
        end else if (op == OP_STORE) begin
          state_n = S_MEMWRITE;
        end else begin
          state_n = S_MEMREAD;
        end
      S_MEMREAD:
        if (mem_ready) state_n = S_MEMWB;
      S_MEMWB:
        state_n = S_FETCH;
      S_MEMWRITE:
        if (mem_ready) state_n = S_FETCH;
      S_EXECR:
        state_n = S_ALUWB;
      S_EXECI:
        if (funct3 == 3'b001 && funct7b5) begin
          state_n = S_TRAP;
          ill_set = 1'b1;
        end else begin
          state_n = S_ALUWB;
        end
      S_LUI,
      S_JAL:
        state_n = S_ALUWB;
      S_ALUWB:
        state_n = S_FETCH;
      S_BRANCH:
        if (!br_legal) begin
          state_n = S_TRAP;
          ill_set = 1'b1;
        end else begin
          state_n = S_FETCH;
        end
      S_TRAP:
        state_n = S_TRAP;
      default:
        state_n = S_FETCH;
    endcase
    if (timeout) begin
      state_n = S_TRAP;
      bus_set = 1'b1;
    end
  end

  assign cnt_n = (state_n != state)       ? 8'd0 :
                 (waiting && !mem_ready) ? cnt + 8'd1 :
                 cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      cnt           <= 8'd0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (ill_set) illegal_instr <= 1'b1;
      if (bus_set) bus_error     <= 1'b1;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    unique case (1'b1)
      (op == OP_STORE): ImmSrc = 3'b001;
      (op == OP_BR):    ImmSrc = 3'b010;
      (op == OP_JAL):   ImmSrc = 3'b011;
      (op == OP_LUI):   ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:
        AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, funct7b5, funct7b5);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct3, 1'b0, funct7b5);
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_ALUWB:
        RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = br_alu;
        PCWrite    = br_legal && br_taken;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: vector table, directed corner
// sequences and random instruction streams against a phase-list model.
module tb_multicycle_controller;

  localparam int TO = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal_instr;
  logic       bus_error;
  logic [3:0] state_dbg;

  multicycle_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXR, P_EXI, P_LUI, P_JAL, P_ALUWB, P_BRANCH, P_TRAP
  } ph_t;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic       bus;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [3:0] alu;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         len;
    logic [3:0] alu;
    logic       ill;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  logic exp_ill = 1'b0;
  logic exp_bus = 1'b0;

  function automatic logic [3:0] alu_of(logic [2:0] f, logic f7, bit imm);
    logic [3:0] base [8];
    base = '{4'h0, 4'h6, 4'h5, 4'h8, 4'h4, 4'h9, 4'h3, 4'h2};
    if (f == 3'd0 && f7 && !imm) return 4'h1;
    if (f == 3'd5 && f7) return 4'h7;
    return base[f];
  endfunction

  function automatic logic [2:0] imm_of(logic [6:0] o);
    if (o == SW) return 3'b001;
    if (o == BR) return 3'b010;
    if (o == JL) return 3'b011;
    if (o == LU) return 3'b100;
    return 3'b000;
  endfunction

  function automatic outs_t model(ph_t p);
    outs_t e;
    logic [1:0] bsel;
    e     = '0;
    e.st  = 4'(p);
    e.ill = exp_ill;
    e.bus = exp_bus;
    e.imm = imm_of(op);
    bsel  = funct3[2:1];
    case (p)
      P_FETCH:    begin e.sb = 2; e.rs = 2; e.irw = mem_ready; e.pcw = mem_ready; end
      P_DECODE:   begin e.sa = 1; e.sb = 1; end
      P_MEMADR:   begin e.sa = 2; e.sb = 1; end
      P_MEMREAD:  e.adr = 1;
      P_MEMWB:    begin e.rs = 1; e.rw = 1; end
      P_MEMWRITE: begin e.adr = 1; e.mw = 1; end
      P_EXR:      begin e.sa = 2; e.alu = alu_of(funct3, funct7b5, 0); end
      P_EXI:      begin e.sa = 2; e.sb = 1; e.alu = alu_of(funct3, funct7b5, 1); end
      P_LUI:      begin e.sa = 3; e.sb = 1; end
      P_JAL:      begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      P_ALUWB:    e.rw = 1;
      P_BRANCH: begin
        e.sa  = 2;
        e.alu = (bsel == 0) ? 4'h1 : (bsel == 2) ? 4'h5 :
                (bsel == 3) ? 4'h8 : 4'h0;
        e.pcw = (bsel != 1) && (Zero ^ funct3[0] ^ funct3[2]);
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input ph_t p, input string tag);
    outs_t e;
    outs_t g;
    #2;
    e     = model(p);
    g.st  = state_dbg;
    g.ill = illegal_instr;
    g.bus = bus_error;
    g.pcw = PCWrite;
    g.adr = AdrSrc;
    g.mw  = MemWrite;
    g.irw = IRWrite;
    g.rw  = RegWrite;
    g.rs  = ResultSrc;
    g.sa  = ALUSrcA;
    g.sb  = ALUSrcB;
    g.imm = ImmSrc;
    g.alu = ALUControl;
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s/%s: got %h expected %h", tag, p.name(), g, e);
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    exp_ill   = 1'b0;
    exp_bus   = 1'b0;
    check(P_FETCH, "reset");
    tick();
    rst_n = 1'b1;
  endtask

  // Runs one instruction from FETCH; sf/sm are mem_ready stall counts
  // for the fetch and the data access.
  task automatic run_instr(
    input  logic [6:0] iop,
    input  logic [2:0] if3,
    input  logic       if7,
    input  logic       iz,
    input  int         sf,
    input  int         sm,
    input  string      tag,
    output int         cycles,
    output bit         trapped
  );
    ph_t q[$];
    ph_t p;
    int  n;
    op = iop; funct3 = if3; funct7b5 = if7; Zero = iz;
    q = '{P_FETCH, P_DECODE};
    case (iop)
      LW: if (if3 == 3'd2) q = {q, P_MEMADR, P_MEMREAD, P_MEMWB};
          else q = {q, P_MEMADR, P_TRAP};
      SW: if (if3 == 3'd2) q = {q, P_MEMADR, P_MEMWRITE};
          else q = {q, P_MEMADR, P_TRAP};
      RT: q = {q, P_EXR, P_ALUWB};
      IT: if (if3 == 3'd1 && if7) q = {q, P_EXI, P_TRAP};
          else q = {q, P_EXI, P_ALUWB};
      BR: if (if3 == 3'd2 || if3 == 3'd3) q = {q, P_BRANCH, P_TRAP};
          else q = {q, P_BRANCH};
      JL: q = {q, P_JAL, P_ALUWB};
      LU: q = {q, P_LUI, P_ALUWB};
      default: q = {q, P_TRAP};
    endcase
    cycles  = 0;
    trapped = 0;
    foreach (q[i]) begin
      p = q[i];
      if (p == P_TRAP) begin
        exp_ill = 1'b1;
        check(p, tag);
        trapped = 1;
      end else if (p == P_FETCH || p == P_MEMREAD || p == P_MEMWRITE) begin
        n = (p == P_FETCH) ? sf : sm;
        for (int w = 0; w <= n; w++) begin
          mem_ready = (w == n);
          check(p, tag);
          tick();
          cycles++;
        end
      end else begin
        mem_ready = 1'($urandom);
        check(p, tag);
        tick();
        cycles++;
      end
    end
  endtask

  vec_t vt[16];
  int   cyc;
  bit   trp;
  int   len;
  logic [3:0] got_alu;
  logic [6:0] ops [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 0; Zero = 0;
    mem_ready = 0;

    vt[0]  = '{RT, 3'd0, 1'b0, 1'b0, 4, 4'h0, 1'b0};
    vt[1]  = '{RT, 3'd0, 1'b1, 1'b0, 4, 4'h1, 1'b0};
    vt[2]  = '{IT, 3'd5, 1'b1, 1'b0, 4, 4'h7, 1'b0};
    vt[3]  = '{IT, 3'd0, 1'b1, 1'b0, 4, 4'h0, 1'b0};
    vt[4]  = '{IT, 3'd1, 1'b1, 1'b0, 3, 4'h6, 1'b1};
    vt[5]  = '{RT, 3'd3, 1'b0, 1'b0, 4, 4'h8, 1'b0};
    vt[6]  = '{BR, 3'd0, 1'b0, 1'b1, 3, 4'h1, 1'b0};
    vt[7]  = '{BR, 3'd6, 1'b0, 1'b1, 3, 4'h8, 1'b0};
    vt[8]  = '{BR, 3'd5, 1'b0, 1'b0, 3, 4'h5, 1'b0};
    vt[9]  = '{LW, 3'd2, 1'b0, 1'b0, 5, 4'h0, 1'b0};
    vt[10] = '{SW, 3'd2, 1'b0, 1'b0, 4, 4'h0, 1'b0};
    vt[11] = '{LW, 3'd0, 1'b0, 1'b0, 3, 4'h0, 1'b1};
    vt[12] = '{JL, 3'd0, 1'b0, 1'b0, 4, 4'h0, 1'b0};
    vt[13] = '{LU, 3'd0, 1'b0, 1'b0, 4, 4'h0, 1'b0};
    vt[14] = '{7'b1111111, 3'd0, 1'b0, 1'b0, 2, 4'hF, 1'b1};
    vt[15] = '{BR, 3'd2, 1'b0, 1'b0, 3, 4'h0, 1'b1};

    for (int k = 0; k < 16; k++) begin
      do_reset();
      op = vt[k].op; funct3 = vt[k].f3; funct7b5 = vt[k].f7;
      Zero = vt[k].z; mem_ready = 1'b1;
      len = 0; got_alu = 4'hF;
      for (int c = 1; c <= 8; c++) begin
        #2;
        if (c == 3) got_alu = ALUControl;
        tick();
        if (state_dbg == 4'd0 || state_dbg == 4'd12) begin
          len = c;
          break;
        end
      end
      expect_int($sformatf("vec%0d_len", k), len, vt[k].len);
      expect_int($sformatf("vec%0d_alu", k), int'(got_alu), int'(vt[k].alu));
      expect_int($sformatf("vec%0d_ill", k), int'(illegal_instr), int'(vt[k].ill));
    end

    do_reset();
    run_instr(RT, 3'd0, 1'b0, 1'b0, 0, 0, "add", cyc, trp);
    expect_int("add_cycles", cyc, 4);
    run_instr(RT, 3'd0, 1'b1, 1'b0, 0, 0, "sub", cyc, trp);
    run_instr(IT, 3'd5, 1'b1, 1'b0, 0, 0, "srai", cyc, trp);
    run_instr(BR, 3'd0, 1'b0, 1'b1, 0, 0, "beq", cyc, trp);
    expect_int("beq_cycles", cyc, 3);
    run_instr(BR, 3'd6, 1'b0, 1'b1, 0, 0, "bltu", cyc, trp);
    run_instr(LW, 3'd2, 1'b0, 1'b0, 0, 3, "lw_stall", cyc, trp);
    expect_int("lw_stall_cycles", cyc, 8);
    run_instr(SW, 3'd2, 1'b0, 1'b0, 0, TO - 1, "sw_edge", cyc, trp);
    expect_int("sw_edge_bus", int'(bus_error), 0);
    run_instr(LW, 3'd2, 1'b0, 1'b0, TO - 1, 0, "fetch_edge", cyc, trp);
    expect_int("fetch_edge_cycles", cyc, TO + 4);

    do_reset();
    op = SW; funct3 = 3'd2; funct7b5 = 0; Zero = 0; mem_ready = 1'b1;
    check(P_FETCH, "to_seq"); tick();
    check(P_DECODE, "to_seq"); tick();
    check(P_MEMADR, "to_seq"); tick();
    mem_ready = 1'b0;
    for (int w = 0; w < TO; w++) begin
      check(P_MEMWRITE, "to_wait");
      tick();
    end
    exp_bus = 1'b1;
    check(P_TRAP, "to_trap");
    mem_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick();
      check(P_TRAP, "to_hold");
    end
    do_reset();

    run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, "badop", cyc, trp);
    expect_int("badop_trapped", int'(trp), 1);
    do_reset();

    op = SW; funct3 = 3'd2; mem_ready = 1'b1;
    check(P_FETCH, "rst_mid"); tick();
    check(P_DECODE, "rst_mid"); tick();
    check(P_MEMADR, "rst_mid"); tick();
    mem_ready = 1'b0;
    check(P_MEMWRITE, "rst_mid");
    rst_n = 1'b0;
    #1;
    expect_int("rst_mid_memwrite", int'(MemWrite), 0);
    expect_int("rst_mid_state", int'(state_dbg), 0);
    tick();
    rst_n = 1'b1;
    check(P_FETCH, "rst_mid_after");

    ops = '{LW, SW, RT, IT, BR, JL, LU};
    for (int r = 0; r < 150; r++) begin
      int   idx;
      logic [6:0] rop;
      idx = $urandom_range(0, 8);
      rop = (idx < 7) ? ops[idx] : 7'($urandom);
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2),
                "rand", cyc, trp);
      if (trp) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
